// File: rtl/sha_dbl_seq.sv
// Sequencer that drives a SHA-256 compression unit through the fixed 9-op double-hash table.
// Optional START_MID entry at op 3 (reusing the bank-1 midstate) is enabled by defining SHA_MIDSTATE_EN.
module sha_dbl_seq #(
    parameter int         TIMEOUT         = 1023,
    parameter logic [7:0] CMD_IDLE        = 8'd0,
    parameter logic [7:0] CMD_LOAD_H      = 8'd1,
    parameter logic [7:0] CMD_HASH        = 8'd2,
    parameter logic [7:0] CMD_SUM_STORE_H = 8'd3,
    parameter logic [7:0] CMD_SUM_STORE_M = 8'd4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
`ifdef SHA_MIDSTATE_EN
    input  logic       start_mid,
`endif
    input  logic       rdy,
    output logic [7:0] cmd,
    output logic [1:0] h_rd_bank,
    output logic [1:0] h_wr_bank,
    output logic [1:0] m_blk,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [3:0] op_idx
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RELEASE,
        S_FINISH,
        S_FAULT
    } state_t;

    typedef struct packed {
        logic [7:0] cmd;
        logic [1:0] rd;
        logic [1:0] wr;
        logic [1:0] blk;
    } op_t;

    localparam logic [9:0] WDOG_LIMIT = 10'(TIMEOUT);

    state_t     state;
    logic [9:0] wdog;
    logic [9:0] wdog_inc;
    logic [3:0] first_op;
    op_t        first_entry;
    op_t        next_entry;

    // Double-SHA op table: first block, second block, then hash of the first digest.
    function automatic op_t op_entry(input logic [3:0] idx);
        op_t e;
        case (idx)
            4'd0:    e = '{CMD_LOAD_H,      2'd0, 2'd0, 2'd0};
            4'd1:    e = '{CMD_HASH,        2'd0, 2'd0, 2'd0};
            4'd2:    e = '{CMD_SUM_STORE_H, 2'd0, 2'd1, 2'd0};
            4'd3:    e = '{CMD_LOAD_H,      2'd1, 2'd1, 2'd1};
            4'd4:    e = '{CMD_HASH,        2'd1, 2'd1, 2'd1};
            4'd5:    e = '{CMD_SUM_STORE_M, 2'd1, 2'd1, 2'd2};
            4'd6:    e = '{CMD_LOAD_H,      2'd0, 2'd2, 2'd2};
            4'd7:    e = '{CMD_HASH,        2'd0, 2'd2, 2'd2};
            4'd8:    e = '{CMD_SUM_STORE_H, 2'd0, 2'd2, 2'd2};
            default: e = '{CMD_IDLE,        2'd0, 2'd0, 2'd0};
        endcase
        return e;
    endfunction

    assign wdog_inc = (wdog == 10'h3FF) ? wdog : wdog + 10'd1;

`ifdef SHA_MIDSTATE_EN
    assign first_op = start_mid ? 4'd3 : 4'd0;
    logic start_any;
    assign start_any = start | start_mid;
`else
    assign first_op = 4'd0;
    logic start_any;
    assign start_any = start;
`endif

    assign first_entry = op_entry(first_op);
    assign next_entry  = op_entry(op_idx + 4'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cmd       <= CMD_IDLE;
            op_idx    <= 4'd0;
            h_rd_bank <= 2'd0;
            h_wr_bank <= 2'd0;
            m_blk     <= 2'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            wdog      <= 10'd0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    cmd <= CMD_IDLE;
                    if (start_any) begin
                        state     <= S_ISSUE;
                        op_idx    <= first_op;
                        cmd       <= first_entry.cmd;
                        h_rd_bank <= first_entry.rd;
                        h_wr_bank <= first_entry.wr;
                        m_blk     <= first_entry.blk;
                        busy      <= 1'b1;
                        err       <= 1'b0;
                    end
                end
                S_ISSUE: begin
                    wdog  <= 10'd0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (rdy) begin
                        cmd   <= CMD_IDLE;
                        state <= S_RELEASE;
                    end else if (wdog_inc >= WDOG_LIMIT) begin
                        cmd   <= CMD_IDLE;
                        err   <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_FAULT;
                    end else begin
                        wdog <= wdog_inc;
                    end
                end
                // Hold the banks until the unit drops RDY so it never sees a stale handshake.
                S_RELEASE: begin
                    if (!rdy) begin
                        if (op_idx < 4'd8) begin
                            op_idx    <= op_idx + 4'd1;
                            cmd       <= next_entry.cmd;
                            h_rd_bank <= next_entry.rd;
                            h_wr_bank <= next_entry.wr;
                            m_blk     <= next_entry.blk;
                            state     <= S_ISSUE;
                        end else begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= S_FINISH;
                        end
                    end
                end
                S_FINISH: begin
                    state <= S_IDLE;
                end
                S_FAULT: begin
                    cmd   <= CMD_IDLE;
                    state <= S_IDLE;
                end
                default: begin
                    cmd   <= CMD_IDLE;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
